// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel switch debouncer.
// Each channel runs its raw input through a synchroniser chain, then a
// stability counter that must see the new level for L consecutive cycles
// before the debounced level is updated. Single-cycle rise/fall pulses are
// produced alongside the updated level. Release can be filtered like press
// (SYMMETRIC=1) or accepted after a single disagreeing cycle (SYMMETRIC=0).

module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int THRESHOLD   = 32768,
  parameter int SYNC_STAGES = 2,
  parameter int SYMMETRIC   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] Input,
  output logic [CHANNELS-1:0] Output,
  output logic [CHANNELS-1:0] Rise,
  output logic [CHANNELS-1:0] Fall,
  output logic [CHANNELS-1:0] Busy,
  output logic                Changed
);

  // Compare values are L-1: the counter reaches L-1 on the cycle before the
  // accepting edge, so the new level lands exactly L edges after Y changes.
  localparam logic [CNT_WIDTH-1:0] LIM_RISE = CNT_WIDTH'(THRESHOLD - 1);
  localparam logic [CNT_WIDTH-1:0] LIM_FALL = (SYMMETRIC != 0) ? LIM_RISE
                                                               : {CNT_WIDTH{1'b0}};

  logic [CHANNELS-1:0]  sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0]  y_s;
  logic [CHANNELS-1:0]  level_r;
  logic [CHANNELS-1:0]  rise_r;
  logic [CHANNELS-1:0]  fall_r;
  logic [CNT_WIDTH-1:0] cnt_r [CHANNELS];

  logic [CHANNELS-1:0]  level_nxt_s;
  logic [CHANNELS-1:0]  rise_nxt_s;
  logic [CHANNELS-1:0]  fall_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_nxt_s [CHANNELS];
  logic [CHANNELS-1:0]  busy_s;

  assign y_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the raw asynchronous inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {CHANNELS{1'b0}};
      end
    end else begin
      sync_r[0] <= Input;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Per-channel filter decision: clear, count, or accept the new level.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_nxt_s[i] = level_r[i];
      rise_nxt_s[i]  = 1'b0;
      fall_nxt_s[i]  = 1'b0;
      cnt_nxt_s[i]   = {CNT_WIDTH{1'b0}};
      if (y_s[i] == level_r[i]) begin
        // Any agreeing cycle abandons the pending change entirely.
        cnt_nxt_s[i] = {CNT_WIDTH{1'b0}};
      end else if (cnt_r[i] == (level_r[i] ? LIM_FALL : LIM_RISE)) begin
        level_nxt_s[i] = y_s[i];
        rise_nxt_s[i]  = y_s[i];
        fall_nxt_s[i]  = ~y_s[i];
        cnt_nxt_s[i]   = {CNT_WIDTH{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Filter state registers: level, counter and edge pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r <= {CHANNELS{1'b0}};
      rise_r  <= {CHANNELS{1'b0}};
      fall_r  <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Busy flags a pending candidate change (counter non-zero).
  always_comb begin
    busy_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      busy_s[i] = (cnt_r[i] != {CNT_WIDTH{1'b0}});
    end
  end

  assign Output  = level_r;
  assign Rise    = rise_r;
  assign Fall    = fall_r;
  assign Busy    = busy_s;
  assign Changed = |(rise_r | fall_r);

endmodule
